// File: rtl/writeback_unit_if.sv
// Load-result handshake between the memory path and the writeback unit.
// The master offers a result; the slave (writeback FIFO) returns ready.
interface writeback_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_dest;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;

   modport master (output mem_valid, mem_dest, mem_data, input mem_ready);
   modport slave  (input mem_valid, mem_dest, mem_data, output mem_ready);
endinterface

// File: rtl/writeback_unit.sv
// Register-file write port owner: merges ALU and buffered load results into one
// registered write per cycle and tracks pending destinations for hazard stalls.
module writeback_unit #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] inst_read_reg_addr1,
   input  logic [ADDR_W-1:0] inst_read_reg_addr2,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_dest,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_dest,
   input  logic [DATA_W-1:0] alu_data,
   writeback_unit_if.slave   mem,
   output logic              stall_flag,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_wr_addr,
   output logic [DATA_W-1:0] reg_wr_data,
   output logic [5:0]        pending_count,
   output logic              wb_error
);

   localparam int NREG = 1 << ADDR_W;
   localparam int PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [ADDR_W-1:0] fifo_dest [DEPTH];
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW:0]       count;

   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pending_nxt;
   logic [5:0]        count_nxt;

   logic              push;
   logic              pop;
   logic              issue_ok;
   logic              sel_valid;
   logic [ADDR_W-1:0] sel_dest;
   logic [DATA_W-1:0] sel_data;

   assign mem.mem_ready = (count != FULL_CNT);
   assign push          = mem.mem_valid & mem.mem_ready;
   assign pop           = ~alu_valid & (count != '0);

   assign stall_flag = pending[inst_read_reg_addr1] | pending[inst_read_reg_addr2] |
                       (issue_valid & pending[issue_dest]);
   assign issue_ok   = issue_valid & ~stall_flag & (issue_dest != '0);

   // ALU has no backpressure, so it always wins; the FIFO drains on idle ALU cycles.
   always_comb begin
      sel_valid = 1'b0;
      sel_dest  = '0;
      sel_data  = '0;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_dest  = alu_dest;
         sel_data  = alu_data;
      end else if (pop) begin
         sel_valid = 1'b1;
         sel_dest  = fifo_dest[rd_ptr];
         sel_data  = fifo_data[rd_ptr];
      end
   end

   // Clear applied before set so a same-address collision leaves the bit set.
   always_comb begin
      pending_nxt = pending;
      if (reg_wr) pending_nxt[reg_wr_addr] = 1'b0;
      if (issue_ok) pending_nxt[issue_dest] = 1'b1;
      count_nxt = '0;
      for (int i = 0; i < NREG; i++) count_nxt = count_nxt + 6'(pending_nxt[i]);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_dest[wr_ptr] <= mem.mem_dest;
         fifo_data[wr_ptr] <= mem.mem_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         pending       <= '0;
         pending_count <= '0;
         wb_error      <= 1'b0;
         reg_wr        <= 1'b0;
         reg_wr_addr   <= '0;
         reg_wr_data   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         pending       <= pending_nxt;
         pending_count <= count_nxt;
         if (reg_wr && !pending[reg_wr_addr]) wb_error <= 1'b1;
         reg_wr <= sel_valid & (sel_dest != '0);
         if (sel_valid) begin
            reg_wr_addr <= sel_dest;
            reg_wr_data <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a queue/array reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_writeback_unit;
   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic [4:0]  addr1, addr2;
   logic        issue_valid;
   logic [4:0]  issue_dest;
   logic        alu_valid;
   logic [4:0]  alu_dest;
   logic [31:0] alu_data;
   logic        stall_flag, reg_wr, wb_error;
   logic [4:0]  reg_wr_addr;
   logic [31:0] reg_wr_data;
   logic [5:0]  pending_count;

   writeback_unit_if #(.DATA_W(32), .ADDR_W(5)) mem_if ();

   writeback_unit #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset),
      .inst_read_reg_addr1(addr1), .inst_read_reg_addr2(addr2),
      .issue_valid(issue_valid), .issue_dest(issue_dest),
      .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
      .mem(mem_if),
      .stall_flag(stall_flag), .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr),
      .reg_wr_data(reg_wr_data), .pending_count(pending_count), .wb_error(wb_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: set of pending registers, queue of buffered loads,
   // and the write that the register file should see this cycle.
   typedef struct { logic [4:0] d; logic [31:0] v; } load_t;
   load_t       q[$];
   bit          pm[32];
   logic        m_wr;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_err;

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 32; i++) n += pm[i];
      return n;
   endfunction

   function automatic logic model_stall();
      return pm[addr1] | pm[addr2] | (issue_valid & pm[issue_dest]);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
         for (int i = 0; i < 32; i++) pm[i] = 0;
         m_wr = 0; m_addr = 0; m_data = 0; m_err = 0;
      end else begin
         logic stall_now, ready_now;
         load_t ld;
         stall_now = model_stall();
         ready_now = (q.size() < DEPTH);
         if (m_wr) begin
            if (!pm[m_addr]) m_err = 1;
            pm[m_addr] = 0;
         end
         if (issue_valid && !stall_now && issue_dest != 0) pm[issue_dest] = 1;
         if (alu_valid) begin
            m_wr = (alu_dest != 0); m_addr = alu_dest; m_data = alu_data;
         end else if (q.size() > 0) begin
            ld = q.pop_front();
            m_wr = (ld.d != 0); m_addr = ld.d; m_data = ld.v;
         end else begin
            m_wr = 0;
         end
         if (mem_if.mem_valid && ready_now) begin
            ld.d = mem_if.mem_dest; ld.v = mem_if.mem_data;
            q.push_back(ld);
         end
      end
   end

   always @(negedge clk) begin
      chk("model reg_wr", reg_wr, m_wr);
      chk("model reg_wr_addr", reg_wr_addr, m_addr);
      chk("model reg_wr_data", reg_wr_data, m_data);
      chk("model pending_count", pending_count, model_count());
      chk("model wb_error", wb_error, m_err);
      chk("model mem_ready", mem_if.mem_ready, q.size() < DEPTH);
      chk("model stall_flag", stall_flag, model_stall());
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      addr1 = 0; addr2 = 0;
      issue_valid = 0; issue_dest = 0;
      alu_valid = 0; alu_dest = 0; alu_data = 0;
      mem_if.mem_valid = 0; mem_if.mem_dest = 0; mem_if.mem_data = 0;
   endtask

   task automatic issue(input logic [4:0] d);
      issue_valid = 1; issue_dest = d;
      tick();
      issue_valid = 0; issue_dest = 0;
   endtask

   initial begin
      idle();
      reset = 0;
      issue_valid = 1; issue_dest = 7;
      alu_valid = 1; alu_dest = 4; alu_data = 32'h55;
      mem_if.mem_valid = 1; mem_if.mem_dest = 9; mem_if.mem_data = 32'h66;
      repeat (3) tick();
      chk("rst reg_wr", reg_wr, 0);
      chk("rst addr", reg_wr_addr, 0);
      chk("rst data", reg_wr_data, 0);
      chk("rst pending", pending_count, 0);
      chk("rst mem_ready", mem_if.mem_ready, 1);
      chk("rst wb_error", wb_error, 0);
      idle();
      tick();
      reset = 1;
      tick();

      // ALU RAW
      issue(8);
      chk("raw pending1", pending_count, 1);
      addr1 = 8; #1;
      chk("raw stall", stall_flag, 1);
      alu_valid = 1; alu_dest = 8; alu_data = 32'h1234;
      tick();
      chk("raw wr", reg_wr, 1);
      chk("raw addr", reg_wr_addr, 8);
      chk("raw data", reg_wr_data, 32'h1234);
      chk("raw stall held", stall_flag, 1);
      alu_valid = 0;
      tick();
      chk("raw stall clr", stall_flag, 0);
      chk("raw pending0", pending_count, 0);
      addr1 = 0;

      // ALU/load collision
      issue(5);
      issue(6);
      chk("col pending2", pending_count, 2);
      alu_valid = 1; alu_dest = 6; alu_data = 32'hA;
      mem_if.mem_valid = 1; mem_if.mem_dest = 5; mem_if.mem_data = 32'hB;
      tick();
      idle();
      chk("col first addr", reg_wr_addr, 6);
      chk("col first data", reg_wr_data, 32'hA);
      tick();
      chk("col second wr", reg_wr, 1);
      chk("col second addr", reg_wr_addr, 5);
      chk("col second data", reg_wr_data, 32'hB);
      tick();
      chk("col pending0", pending_count, 0);

      // FIFO full with ALU starving the FIFO
      for (int r = 10; r <= 19; r++) issue(5'(r));
      chk("full pending10", pending_count, 10);
      for (int k = 0; k < 4; k++) begin
         alu_valid = 1; alu_dest = 5'(14 + k); alu_data = 32'(14 + k);
         mem_if.mem_valid = 1; mem_if.mem_dest = 5'(10 + k); mem_if.mem_data = 32'h100 + 32'(k);
         tick();
      end
      alu_dest = 18; alu_data = 18;
      mem_if.mem_dest = 9; mem_if.mem_data = 32'h999;
      #1;
      chk("full ready0", mem_if.mem_ready, 0);
      tick();
      alu_dest = 19; alu_data = 19;
      chk("full ready0 held", mem_if.mem_ready, 0);
      tick();
      chk("full alu19", reg_wr_addr, 19);
      idle();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("drain wr", reg_wr, 1);
         chk("drain addr", reg_wr_addr, 5'(10 + k));
         chk("drain data", reg_wr_data, 32'h100 + 32'(k));
         if (k == 0) chk("drain ready1", mem_if.mem_ready, 1);
      end
      tick();
      chk("drain pending0", pending_count, 0);

      // Register 0
      alu_valid = 1; alu_dest = 0; alu_data = 32'hFFFF;
      tick();
      idle();
      chk("r0 no wr", reg_wr, 0);
      issue_valid = 1; issue_dest = 0; #1;
      chk("r0 stall", stall_flag, 0);
      tick();
      idle();
      chk("r0 pending", pending_count, 0);

      // Write to a non-pending register
      alu_valid = 1; alu_dest = 3; alu_data = 32'h33;
      tick();
      idle();
      chk("err wr", reg_wr, 1);
      chk("err not yet", wb_error, 0);
      tick();
      chk("err set", wb_error, 1);
      repeat (3) tick();
      chk("err sticky", wb_error, 1);

      // Reset in the middle of traffic
      issue(2);
      alu_valid = 1; alu_dest = 2; alu_data = 32'h22;
      mem_if.mem_valid = 1; mem_if.mem_dest = 2; mem_if.mem_data = 32'h23;
      tick();
      chk("mid wr before", reg_wr, 1);
      reset = 0; #1;
      chk("mid wr drop", reg_wr, 0);
      chk("mid pending", pending_count, 0);
      chk("mid err clr", wb_error, 0);
      chk("mid ready", mem_if.mem_ready, 1);
      idle();
      tick();
      reset = 1;
      tick();
      tick();
      chk("mid fifo discarded", reg_wr, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writer side of the decode-stage register file: owns the single write port (reg_wr, reg_wr_addr, reg_wr_data) and the stall_flag input of the register file.
- Merges results from the ALU path (no backpressure) and the memory/load path (valid/ready, buffered in a FIFO) into one registered write per cycle.
- Keeps a per-register pending-write scoreboard so decode stalls on RAW/WAW hazards.

Parameters:
DEPTH, 4, entries in memory-result FIFO (power of 2, >=2)
DATA_W, 32, register data width
ADDR_W, 5, register address width (32 registers)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
inst_read_reg_addr1  input  ADDR_W  decode source register 1
inst_read_reg_addr2  input  ADDR_W  decode source register 2
issue_valid  input  1  decode wants to issue an instruction writing issue_dest
issue_dest  input  ADDR_W  destination of issuing instruction
alu_valid  input  1  ALU result present this cycle
alu_dest  input  ADDR_W  ALU result destination
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load result offered
mem_dest  input  ADDR_W  load destination
mem_data  input  DATA_W  load data
mem_ready  output  1  FIFO can accept (combinational: count < DEPTH)
stall_flag  output  1  combinational hazard stall to decode/register file
reg_wr  output  1  register-file write enable (registered)
reg_wr_addr  output  ADDR_W  write address (registered)
reg_wr_data  output  DATA_W  write data (registered)
pending_count  output  6  number of registers currently pending
wb_error  output  1  sticky: committed a write to a non-pending register

Behaviour:
- Reset (reset=0, async): reg_wr=0, reg_wr_addr=0, reg_wr_data=0, FIFO empty, pending[31:0]=0, pending_count=0, wb_error=0. mem_ready=1, stall_flag=0. Deassertion is synchronous to clk by the system.
- Stall: stall_flag = pending[addr1] | pending[addr2] | (issue_valid & pending[issue_dest]). Register 0 is never pending.
- Issue: accepted on an edge when issue_valid=1, stall_flag=0, issue_dest!=0. Sets pending[issue_dest]. Issue_valid while stalled is ignored.
- Commit selection, evaluated each edge:
  - alu_valid=1: ALU wins. Register alu_dest/alu_data to the outputs; FIFO not popped.
  - else FIFO non-empty: pop the head into the outputs.
  - else reg_wr<=0 (addr/data hold).
- reg_wr<=1 only when the selected dest!=0. A dest-0 result is consumed but produces reg_wr=0.
- Latency: ALU result sampled at edge N -> reg_wr high from N to N+1; register file captures at N+1. Load pushed at edge N -> earliest reg_wr from N+1 (no FIFO bypass).
- FIFO:
  - Push when mem_valid & mem_ready. Strict FIFO order.
  - Push and pop in the same cycle allowed when not full.
  - When full, mem_ready=0 even if a pop occurs that cycle; mem_valid is then ignored and the source must hold.
  - Pointers wrap modulo DEPTH.
- Pending clear: at each edge with reg_wr=1, clear pending[reg_wr_addr]. That edge is the one on which the register file writes. stall drops after it, so decode reads the new value on the next edge.
  - If pending[reg_wr_addr] was already 0, set wb_error (sticky until reset).
  - Set and clear of the same address on one edge cannot occur, because WAW stalls the issue. If it does occur, set wins.
- pending_count = popcount(pending), updated with pending.
- ALU starvation of the FIFO is allowed; no fairness is required.
- Reset mid-operation: FIFO contents and pending bits are discarded, and reg_wr drops immediately.

Test Plan:
- Reset: hold reset=0 with stimulus active -> all outputs at reset values, mem_ready=1. Release, then issue dest 8 -> pending_count=1.
- ALU RAW: issue dest 8; set addr1=8 -> stall_flag=1. alu_valid dest 8 data 0x1234 at edge N -> reg_wr=1, addr 8, data 0x1234 after N; stall_flag=0 after N+1; pending_count=0.
- Collision: issue 5 and 6. alu (6, 0xA) and mem (5, 0xB) in the same cycle -> write 6/0xA first, then 5/0xB on the next cycle; both pending bits clear.
- FIFO full: issue 10-13; alu_valid held high to other pending regs; push 4 loads -> mem_ready=0, 5th offer held. Drop alu_valid -> loads commit in order 10,11,12,13 on consecutive cycles; mem_ready returns to 1 after the first pop.
- Reg 0: alu_valid dest 0 data 0xFFFF -> reg_wr stays 0; issue_dest 0 -> no pending, stall_flag=0.
- Error: commit alu dest 3 without prior issue -> reg_wr=1, wb_error=1 and stays 1 until reset.
